// File: rtl/stepper_unipolar_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : stepper_unipolar_ctrl_if
// Brief    : Motion-control <-> stepper sequencer bundle (command in, coils out).
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface stepper_unipolar_ctrl_if #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 16,
    parameter int POS_W = 24
);
    logic             start;
    logic             stop;
    logic             dir;
    logic [1:0]       mode;
    logic [CNT_W-1:0] steps;
    logic [DIV_W-1:0] period;
    logic             hold;
    logic             jog;
    logic [3:0]       coils;
    logic             busy;
    logic             done;
    logic [POS_W-1:0] position;

    modport master (
        output start, stop, dir, mode, steps, period, hold, jog,
        input  coils, busy, done, position
    );

    modport slave (
        input  start, stop, dir, mode, steps, period, hold, jog,
        output coils, busy, done, position
    );
endinterface

`default_nettype wire

// File: rtl/stepper_unipolar_ctrl.sv
//------------------------------------------------------------------------------
// Module   : stepper_unipolar_ctrl
// Brief    : Unipolar stepper phase sequencer (wave/full/half), counted moves at
//            a programmable rate, signed position. Optional macro STEPPER_JOG_EN
//            adds a continuous jog run.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module stepper_unipolar_ctrl #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 16,
    parameter int POS_W = 24
) (
    input  logic                   clock,
    input  logic                   reset,
    stepper_unipolar_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [2:0]       r_idx;
    logic [DIV_W-1:0] r_presc;
    logic [DIV_W-1:0] r_period;
    logic [CNT_W-1:0] r_remain;
    logic [POS_W-1:0] r_pos;
    logic             r_dir;
    logic [1:0]       r_mode;
    logic             r_busy;
    logic             r_done;

    logic             w_step1;
    logic [2:0]       w_next_idx;
    logic [POS_W-1:0] w_mag;
    logic [POS_W-1:0] w_next_pos;
    logic             w_tick;
    logic             w_halt;
    logic             w_jog_go;
    logic             w_cont;
    logic [3:0]       w_pattern;

`ifdef STEPPER_JOG_EN
    logic r_cont;

    // Continuous flag tracks jog while idle so a plain start always clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cont <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_cont <= bus.jog;
        end
    end

    assign w_jog_go = bus.jog;
    assign w_cont   = r_cont;
    assign w_halt   = bus.stop | (r_cont & ~bus.jog);
`else
    logic unused_jog;
    assign unused_jog = bus.jog;
    assign w_jog_go   = 1'b0;
    assign w_cont     = 1'b0;
    assign w_halt     = bus.stop;
`endif

    // Full uses even indices, wave odd; a single-index move realigns parity.
    assign w_step1    = (r_mode == 2'b10) || (r_idx[0] != (r_mode == 2'b00));
    assign w_next_idx = r_dir ? (r_idx + (w_step1 ? 3'd1 : 3'd2))
                              : (r_idx - (w_step1 ? 3'd1 : 3'd2));
    assign w_mag      = w_step1 ? POS_W'(1) : POS_W'(2);
    assign w_next_pos = r_dir ? (r_pos + w_mag) : (r_pos - w_mag);
    assign w_tick     = (r_presc == r_period);

    always_comb begin
        w_pattern = 4'b0000;
        case (r_idx)
            3'd0: w_pattern = 4'b1001;
            3'd1: w_pattern = 4'b1000;
            3'd2: w_pattern = 4'b1010;
            3'd3: w_pattern = 4'b0010;
            3'd4: w_pattern = 4'b0110;
            3'd5: w_pattern = 4'b0100;
            3'd6: w_pattern = 4'b0101;
            3'd7: w_pattern = 4'b0001;
            default: w_pattern = 4'b0000;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_idx    <= 3'd0;
            r_presc  <= '0;
            r_period <= '0;
            r_remain <= '0;
            r_pos    <= '0;
            r_dir    <= 1'b0;
            r_mode   <= 2'b00;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_jog_go || (bus.start && (bus.steps != '0))) begin
                        r_state  <= ST_RUN;
                        r_busy   <= 1'b1;
                        r_dir    <= bus.dir;
                        r_mode   <= bus.mode;
                        r_period <= bus.period;
                        r_remain <= bus.steps;
                        r_presc  <= '0;
                    end else if (bus.start) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_RUN: begin
                    // A halt request wins over a tick in the same cycle.
                    if (w_halt) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                    end else if (w_tick) begin
                        r_presc <= '0;
                        r_idx   <= w_next_idx;
                        r_pos   <= w_next_pos;
                        if (!w_cont) begin
                            r_remain <= r_remain - CNT_W'(1);
                            if (r_remain == CNT_W'(1)) begin
                                r_state <= ST_DONE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end else begin
                        r_presc <= r_presc + DIV_W'(1);
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.coils    = (r_busy || bus.hold) ? w_pattern : 4'b0000;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.position = r_pos;

endmodule

`default_nettype wire

// File: tb/tb_stepper_unipolar_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_stepper_unipolar_ctrl
// Brief    : Directed self-checking bench for stepper_unipolar_ctrl.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_stepper_unipolar_ctrl;
    localparam int DIV_W = 16;
    localparam int CNT_W = 16;
    localparam int POS_W = 24;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    stepper_unipolar_ctrl_if #(.DIV_W(DIV_W), .CNT_W(CNT_W), .POS_W(POS_W)) bus ();

    stepper_unipolar_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W), .POS_W(POS_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic set_move(input logic d, input logic [1:0] m,
                            input logic [CNT_W-1:0] s, input logic [DIV_W-1:0] p);
        bus.dir    = d;
        bus.mode   = m;
        bus.steps  = s;
        bus.period = p;
    endtask

    // Leaves time at 1 unit after the edge that sampled start.
    task automatic pulse_start();
        @(negedge clock);
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.stop = 1'b0; bus.jog = 1'b0; bus.hold = 1'b1;
        set_move(1'b1, 2'b01, '0, '0);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (bus.coils !== 4'b1001) begin errors++; $display("FAIL reset_coils_hold actual=%b required=%b", bus.coils, 4'b1001); end
        checks++; if (bus.position !== 24'd0) begin errors++; $display("FAIL reset_position actual=%0h required=0", bus.position); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy actual=%b required=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done actual=%b required=0", bus.done); end
        bus.hold = 1'b0;
        #1;
        checks++; if (bus.coils !== 4'b0000) begin errors++; $display("FAIL reset_coils_nohold actual=%b required=0000", bus.coils); end
        bus.hold = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_full_fwd();
        logic [3:0] ec;
        set_move(1'b1, 2'b01, 16'd4, 16'd2);
        pulse_start();
        for (int k = 1; k <= 14; k++) begin
            @(posedge clock);
            #1;
            ec = (k < 3) ? 4'b1001 : (k < 6) ? 4'b1010 : (k < 9) ? 4'b0110 :
                 (k < 12) ? 4'b0101 : 4'b1001;
            checks++; if (bus.coils !== ec) begin errors++; $display("FAIL full_coils k=%0d actual=%b required=%b", k, bus.coils, ec); end
            checks++; if (bus.busy !== (k < 12)) begin errors++; $display("FAIL full_busy k=%0d actual=%b required=%b", k, bus.busy, (k < 12)); end
            checks++; if (bus.done !== (k == 13)) begin errors++; $display("FAIL full_done k=%0d actual=%b required=%b", k, bus.done, (k == 13)); end
        end
        checks++; if (bus.position !== 24'd8) begin errors++; $display("FAIL full_position actual=%0d required=8", bus.position); end
    endtask

    task automatic test_half_rev();
        logic [3:0] ec;
        set_move(1'b0, 2'b10, 16'd3, 16'd0);
        pulse_start();
        for (int k = 1; k <= 5; k++) begin
            @(posedge clock);
            #1;
            ec = (k == 1) ? 4'b0001 : (k == 2) ? 4'b0101 : 4'b0100;
            checks++; if (bus.coils !== ec) begin errors++; $display("FAIL half_coils k=%0d actual=%b required=%b", k, bus.coils, ec); end
            checks++; if (bus.done !== (k == 4)) begin errors++; $display("FAIL half_done k=%0d actual=%b required=%b", k, bus.done, (k == 4)); end
        end
        checks++; if (bus.position !== 24'd5) begin errors++; $display("FAIL half_position actual=%0d required=5", bus.position); end
    endtask

    task automatic test_realign();
        logic [3:0]       ec;
        logic [POS_W-1:0] ep;
        do_reset();
        set_move(1'b1, 2'b10, 16'd1, 16'd0);
        pulse_start();
        repeat (3) @(posedge clock);
        #1;
        checks++; if (bus.coils !== 4'b1000) begin errors++; $display("FAIL align_pre_coils actual=%b required=1000", bus.coils); end
        checks++; if (bus.position !== 24'd1) begin errors++; $display("FAIL align_pre_position actual=%0d required=1", bus.position); end
        set_move(1'b1, 2'b01, 16'd2, 16'd1);
        pulse_start();
        for (int k = 1; k <= 6; k++) begin
            @(posedge clock);
            #1;
            ec = (k < 2) ? 4'b1000 : (k < 4) ? 4'b1010 : 4'b0110;
            ep = (k < 2) ? 24'd1 : (k < 4) ? 24'd2 : 24'd4;
            checks++; if (bus.coils !== ec) begin errors++; $display("FAIL align_full_coils k=%0d actual=%b required=%b", k, bus.coils, ec); end
            checks++; if (bus.position !== ep) begin errors++; $display("FAIL align_full_position k=%0d actual=%0d required=%0d", k, bus.position, ep); end
            checks++; if (bus.done !== (k == 5)) begin errors++; $display("FAIL align_full_done k=%0d actual=%b required=%b", k, bus.done, (k == 5)); end
        end
        set_move(1'b0, 2'b00, 16'd2, 16'd0);
        pulse_start();
        for (int k = 1; k <= 4; k++) begin
            @(posedge clock);
            #1;
            ec = (k == 1) ? 4'b0010 : 4'b1000;
            ep = (k == 1) ? 24'd3 : 24'd1;
            checks++; if (bus.coils !== ec) begin errors++; $display("FAIL align_wave_coils k=%0d actual=%b required=%b", k, bus.coils, ec); end
            checks++; if (bus.position !== ep) begin errors++; $display("FAIL align_wave_position k=%0d actual=%0d required=%0d", k, bus.position, ep); end
        end
    endtask

    task automatic test_stop();
        do_reset();
        set_move(1'b1, 2'b01, 16'd10, 16'd5);
        pulse_start();
        repeat (23) @(posedge clock);
        #1;
        checks++; if (bus.coils !== 4'b0101) begin errors++; $display("FAIL stop_pre_coils actual=%b required=0101", bus.coils); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL stop_pre_busy actual=%b required=1", bus.busy); end
        bus.stop = 1'b1;
        @(posedge clock);
        #1;
        bus.stop = 1'b0;
        checks++; if (bus.coils !== 4'b0101) begin errors++; $display("FAIL stop_coils actual=%b required=0101", bus.coils); end
        checks++; if (bus.position !== 24'd6) begin errors++; $display("FAIL stop_position actual=%0d required=6", bus.position); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL stop_busy actual=%b required=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL stop_done_early actual=%b required=0", bus.done); end
        @(posedge clock);
        #1;
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL stop_done actual=%b required=1", bus.done); end
        @(posedge clock);
        #1;
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL stop_done_width actual=%b required=0", bus.done); end
        checks++; if (bus.coils !== 4'b0101) begin errors++; $display("FAIL stop_idle_coils actual=%b required=0101", bus.coils); end
    endtask

    task automatic test_zero_steps();
        set_move(1'b1, 2'b01, 16'd0, 16'd3);
        pulse_start();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL zero_busy actual=%b required=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL zero_done_early actual=%b required=0", bus.done); end
        @(posedge clock);
        #1;
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL zero_done actual=%b required=1", bus.done); end
        checks++; if (bus.coils !== 4'b0101) begin errors++; $display("FAIL zero_coils actual=%b required=0101", bus.coils); end
        @(posedge clock);
        #1;
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL zero_done_width actual=%b required=0", bus.done); end
        checks++; if (bus.position !== 24'd6) begin errors++; $display("FAIL zero_position actual=%0d required=6", bus.position); end
    endtask

    task automatic test_reset_mid_run();
        set_move(1'b1, 2'b01, 16'd5, 16'd0);
        pulse_start();
        repeat (2) @(posedge clock);
        #1;
        checks++; if (bus.coils !== 4'b1010) begin errors++; $display("FAIL midrst_pre_coils actual=%b required=1010", bus.coils); end
        checks++; if (bus.position !== 24'd10) begin errors++; $display("FAIL midrst_pre_position actual=%0d required=10", bus.position); end
        do_reset();
        checks++; if (bus.coils !== 4'b1001) begin errors++; $display("FAIL midrst_coils actual=%b required=1001", bus.coils); end
        checks++; if (bus.position !== 24'd0) begin errors++; $display("FAIL midrst_position actual=%0d required=0", bus.position); end
        for (int k = 1; k <= 3; k++) begin
            @(posedge clock);
            #1;
            checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_done k=%0d actual=%b required=0", k, bus.done); end
            checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy k=%0d actual=%b required=0", k, bus.busy); end
        end
        bus.hold = 1'b0;
        #1;
        checks++; if (bus.coils !== 4'b0000) begin errors++; $display("FAIL midrst_nohold actual=%b required=0000", bus.coils); end
        bus.hold = 1'b1;
        set_move(1'b0, 2'b10, 16'd1, 16'd0);
        pulse_start();
        @(posedge clock);
        #1;
        checks++; if (bus.position !== 24'hFFFFFF) begin errors++; $display("FAIL pos_wrap actual=%0h required=ffffff", bus.position); end
        checks++; if (bus.coils !== 4'b0001) begin errors++; $display("FAIL idx_wrap_coils actual=%b required=0001", bus.coils); end
    endtask

    initial begin
        test_reset();
        test_full_fwd();
        test_half_rev();
        test_realign();
        test_stop();
        test_zero_steps();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/stepper_unipolar_ctrl.md
Name: stepper_unipolar_ctrl

Overview:
Parametrised unipolar stepper-motor phase sequencer, the successor to the fixed 4-state full-step driver. It supports wave, full-step (two-phase) and half-step modes. It runs a programmed number of steps at a programmable rate in either direction and tracks a signed position count. It sits between the motion-control logic (start/stop/steps/period) and the coil driver stage (4 coil enables P, M, L, Y).

Parameters:
DIV_W, 16, width of step-period prescaler and period input
CNT_W, 16, width of step-count input and remaining-step counter
POS_W, 24, width of signed position counter (two's complement, wraps)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  1-cycle request; accepted only in IDLE
stop  in  1  abort request; effective only in RUN
dir  in  1  1 = forward (index +), 0 = reverse (index -); latched at start
mode  in  2  00 wave, 01 full, 10 half, 11 treated as full; latched at start
steps  in  CNT_W  number of index moves to perform; latched at start
period  in  DIV_W  step interval = period+1 clocks; latched at start
hold  in  1  1 = energise last pattern while idle, 0 = coils off while idle (live, not latched)
jog  in  1  continuous-run request (used only with STEPPER_JOG_EN)
coils  out  4  {P,M,L,Y} = coils[3:0]
busy  out  1  high in RUN
done  out  1  1-cycle pulse on completion or abort
position  out  POS_W  signed index-move count since reset

Behaviour:
- Sequence table, 3-bit index i (wraps 7<->0): 0:1001 1:1000 2:1010 3:0010 4:0110 5:0100 6:0101 7:0001.
- Full mode uses even i; wave uses odd i. Normal move is ±2 in those modes and ±1 in half mode.
- Parity realign: if the latched mode is full/wave and i has the wrong parity, the first move is ±1 and lands on the correct parity. Later moves are ±2. The ±1 move counts as one step.
- coils = table[i] in RUN; in IDLE/DONE, table[i] if hold=1 else 0000. Combinational from registered state.
- Reset: state IDLE, i=0, prescaler=0, remaining=0, position=0, busy=0, done=0. coils = 1001 if hold=1 else 0000.
- FSM IDLE: start & steps!=0 -> RUN. Latch dir/mode/steps/period; prescaler=0.
- FSM IDLE: start & steps==0 -> DONE, no move.
- FSM RUN: prescaler increments each clock. When prescaler==latched period: tick, prescaler=0.
  - On a tick: i moves, remaining decrements, position changes by ±(move size).
  - If remaining reaches 0 on the tick -> DONE.
- stop in RUN -> DONE next edge. stop beats a same-cycle tick: no move, i/position frozen.
- FSM DONE: done=1 for exactly 1 cycle -> IDLE.
- start while RUN or DONE is ignored. Input changes in RUN have no effect except hold, stop and jog.
- Latency: first move becomes visible on coils period+1 clocks after the start edge. Then one move every period+1 clocks. period=0 gives one move per clock.
- position wraps modulo 2^POS_W. The index wraps modulo 8 without a glitch.
- reset asserted mid-RUN: the next edge forces the reset values, no done pulse.

Optional Feature:
STEPPER_JOG_EN
- Defined, in IDLE: jog=1 -> RUN in continuous mode, using dir/mode/period latched as for start. remaining is not used. The motor steps until jog=0 or stop=1, then DONE. jog has priority over start in the same cycle.
- Not defined: the jog input is ignored, and the logic is removed.

Test Plan:
- reset, hold=1 -> coils=1001, position=0, busy=0. hold=0 -> coils=0000.
- mode=01, dir=1, steps=4, period=2, start -> coils 1010,0110,0101,1001 at cycles 3,6,9,12 after start. done pulse at cycle 13. position=+8.
- mode=10, dir=0, steps=3, period=0 from i=0 -> coils 0001,0101,0100 on consecutive clocks. position=-3.
- From i=1 (after one half step), mode=01, dir=1, steps=2 -> first move to i=2 (1010), then i=4 (0110). position +1 then +2.
- steps=10, period=5, stop asserted on a tick cycle after 3 moves -> no 4th move, done pulse, busy=0, position=+6 (full mode).
- start with steps=0 -> done next cycle, coils unchanged. Also: reset mid-RUN -> no done, i=0, position=0.
